// File: rtl/adc_driver_test_pkg.sv
// Shared encodings for the DSO acquisition controller: trigger modes and capture FSM states.
package adc_driver_test_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_STOP   = 2'd2,
        MODE_FORCE  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_PRE   = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    localparam int unsigned SYNC_STAGES = 2;

    // States in which sample ticks turn into buffer writes.
    function automatic logic writes_enabled(input state_e st);
        return (st == ST_PRE) || (st == ST_ARMED) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/adc_driver_test_prescaler.sv
// Sample-rate tick generator: counts 0..divider and pulses the tick on the wrap cycle.
module adc_driver_test_prescaler #(
    parameter int unsigned DEL_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEL_W-1:0] divider_i,
    output logic             tick_o_c
);

    logic [DEL_W-1:0] cnt_q, cnt_d;
    logic [DEL_W-1:0] div_q, div_d;

    assign tick_o_c = (cnt_q == div_q);

    // Divider is picked up only on wrap so a change never truncates the running period.
    always_comb begin
        cnt_d = cnt_q + DEL_W'(1);
        div_d = div_q;
        if (tick_o_c) begin
            cnt_d = '0;
            div_d = divider_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/adc_driver_test.sv
// DSO acquisition controller: circular capture-buffer writes, pre/post trigger fill,
// trigger qualification and valid/ready record hand-off to the readout side.
module adc_driver_test
    import adc_driver_test_pkg::*;
#(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned DEL_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEL_W-1:0] sample_divider,
    input  logic [1:0]       mode,
    input  logic             trigger_req,
    input  logic             ready,
    output logic             valid,
    output logic [DEPTH-1:0] mem_addr,
    output logic             mem_en,
    output logic [DEPTH-1:0] trig_addr,
    output logic             waiting_for_trigger,
    output logic             triggered
);

    localparam int unsigned CNT_W = DEPTH + 1;
    localparam int unsigned HALF  = 2 ** (DEPTH - 1);
    localparam int unsigned FULL  = 2 ** DEPTH;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FULL);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DEPTH-1:0]   trig_addr_q, trig_addr_d;
    logic               mem_en_q, mem_en_d;
    logic               valid_q, valid_d;
    logic               wait_q, wait_d;
    logic               trig_q, trig_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               prev_q;
    logic               edge_c;
    logic               accept_c;
    logic               tick_c;
    mode_e              mode_c;

    assign mode_c = mode_e'(mode);

    adc_driver_test_prescaler #(
        .DEL_W (DEL_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .divider_i (sample_divider),
        .tick_o_c  (tick_c)
    );

    // Two-flop synchronizer plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_req};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PRE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            trig_addr_q <= '0;
            mem_en_q    <= 1'b0;
            valid_q     <= 1'b0;
            wait_q      <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            trig_addr_q <= trig_addr_d;
            mem_en_q    <= mem_en_d;
            valid_q     <= valid_d;
            wait_q      <= wait_d;
            trig_q      <= trig_d;
        end
    end

    // mem_en_q marks a write happening this cycle at mem_addr_q; cnt_q counts writes per phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        accept_c    = 1'b0;

        unique case (state_q)
            ST_PRE: begin
                if (mem_en_q) begin
                    if (cnt_q == HALF_LAST) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ARMED: begin
                unique case (mode_c)
                    MODE_FORCE: accept_c = 1'b1;
                    MODE_AUTO:  accept_c = edge_c || (cnt_q == FULL_CNT);
                    default:    accept_c = edge_c;
                endcase
                // A write coinciding with accept is the trigger sample and counts toward POST.
                if (accept_c) begin
                    state_d     = ST_POST;
                    trig_addr_d = mem_addr_q;
                    cnt_d       = mem_en_q ? CNT_W'(1) : CNT_W'(0);
                end else if (mem_en_q && (cnt_q != FULL_CNT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_POST: begin
                if (mem_en_q) begin
                    if (cnt_q == HALF_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (valid_q && ready) begin
                    state_d = (mode_c == MODE_STOP) ? ST_HOLD : ST_PRE;
                end
            end
            ST_HOLD: begin
                if (mode_c != MODE_STOP) begin
                    state_d = ST_PRE;
                end
            end
            default: begin
                state_d = ST_PRE;
                cnt_d   = '0;
            end
        endcase

        // Gating on the next state keeps the final POST tick from leaking into DONE.
        mem_en_d   = tick_c && writes_enabled(state_d);
        mem_addr_d = mem_en_q ? (mem_addr_q + DEPTH'(1)) : mem_addr_q;
        valid_d    = (state_d == ST_DONE);
        wait_d     = (state_d == ST_ARMED);
        trig_d     = (state_d == ST_POST) || (state_d == ST_DONE);
    end

    assign valid               = valid_q;
    assign mem_addr            = mem_addr_q;
    assign mem_en              = mem_en_q;
    assign trig_addr           = trig_addr_q;
    assign waiting_for_trigger = wait_q;
    assign triggered           = trig_q;

endmodule

// File: tb/tb_adc_driver_test.sv
// Randomized scenario bench for adc_driver_test; expected addresses come from a write-count model.
module tb_adc_driver_test;

    localparam int DEPTH = 6;
    localparam int DEL_W = 24;
    localparam int HALF  = 32;
    localparam int FULL  = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DEL_W-1:0] sample_divider = '0;
    logic [1:0]       mode = 2'd0;
    logic             trigger_req = 1'b0;
    logic             ready = 1'b0;
    logic             valid;
    logic [DEPTH-1:0] mem_addr;
    logic             mem_en;
    logic [DEPTH-1:0] trig_addr;
    logic             waiting_for_trigger;
    logic             triggered;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int addr_base = 0;
    int wr_cyc[$];
    int wr_addr[$];

    adc_driver_test #(.DEPTH(DEPTH), .DEL_W(DEL_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sample_divider      (sample_divider),
        .mode                (mode),
        .trigger_req         (trigger_req),
        .ready               (ready),
        .valid               (valid),
        .mem_addr            (mem_addr),
        .mem_en              (mem_en),
        .trig_addr           (trig_addr),
        .waiting_for_trigger (waiting_for_trigger),
        .triggered           (triggered)
    );

    always #5 clk = ~clk;

    // Write log: cycle index and address of every observed buffer write.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(mem_addr));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2ms, required completion");
        $fatal(1);
    end

    // Model: the n-th write since reset targets address n mod 2**DEPTH.
    function automatic int exp_addr(input int idx);
        return (idx - addr_base) % FULL;
    endfunction

    function automatic int first_write_at(input int c);
        for (int i = 0; i < wr_cyc.size(); i++) if (wr_cyc[i] >= c) return i;
        return -1;
    endfunction

    function automatic int writes_between(input int lo, input int hi);
        int n = 0;
        for (int i = 0; i < wr_cyc.size(); i++) if (wr_cyc[i] >= lo && wr_cyc[i] < hi) n++;
        return n;
    endfunction

    function automatic logic sig_val(input int w);
        case (w)
            0:       return waiting_for_trigger;
            1:       return triggered;
            2:       return valid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_for(input int w, input int budget, output int rise);
        rise = -1;
        for (int i = 0; i < budget; i++) begin
            if (sig_val(w) === 1'b1) begin
                rise = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_divider = 24'd1; mode = 2'd0; trigger_req = 1'b0; ready = 1'b0;
        repeat (3) tick();
        checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d required 0", mem_addr); end
        checks++; if (trig_addr !== 6'd0) begin errors++; $display("FAIL reset_trig_addr: got %0d required 0", trig_addr); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b required 0", mem_en); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid); end
        checks++; if (waiting_for_trigger !== 1'b0) begin errors++; $display("FAIL reset_waiting: got %b required 0", waiting_for_trigger); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered: got %b required 0", triggered); end
    endtask

    // Pre-trigger fill with divider 1; an edge and ready during PRE must be ignored.
    task automatic test_prefill();
        int rise, n, bad_a, bad_s, bad;
        addr_base = wr_cyc.size();
        ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 100 && wr_cyc.size() < addr_base + 5; i++) tick();
        trigger_req = 1'b1;
        repeat (3) tick();
        trigger_req = 1'b0;
        wait_for(0, 400, rise);
        ready = 1'b0;
        checks++;
        if (rise < 0) begin errors++; $display("FAIL prefill_timeout: waiting=%b required 1", waiting_for_trigger); return; end
        n = writes_between(0, rise);
        checks++; if (n != HALF) begin errors++; $display("FAIL prefill_count: got %0d writes required %0d", n, HALF); end
        if (n != HALF) return;
        bad_a = 0; bad_s = 0;
        for (int j = 0; j < HALF; j++) begin
            if (wr_addr[addr_base+j] != exp_addr(addr_base+j)) bad_a++;
            if (j > 0 && wr_cyc[addr_base+j] - wr_cyc[addr_base+j-1] != 2) bad_s++;
        end
        checks++; if (bad_a != 0) begin errors++; $display("FAIL prefill_addr: %0d wrong addresses, required 0", bad_a); end
        checks++; if (bad_s != 0) begin errors++; $display("FAIL prefill_spacing: %0d gaps not 2 clocks, required 0", bad_s); end
        checks++; if (rise != wr_cyc[addr_base+HALF-1] + 1) begin errors++; $display("FAIL armed_latency: rise cycle %0d required %0d", rise, wr_cyc[addr_base+HALF-1] + 1); end
        bad = 0;
        repeat (20) begin
            if (triggered !== 1'b0 || waiting_for_trigger !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pre_edge_dropped: %0d armed cycles triggered, required 0", bad); end
    endtask

    // After acceptance at acc_cyc: 32 contiguous writes from the trigger sample, then idle DONE.
    task automatic test_post_phase(input int acc_cyc);
        int vr, ti, n, bad, fa;
        wait_for(2, 600, vr);
        checks++;
        if (vr < 0) begin errors++; $display("FAIL post_timeout: valid=%b required 1", valid); return; end
        ti = first_write_at(acc_cyc);
        n = writes_between(acc_cyc, vr);
        checks++; if (n != HALF || ti < 0) begin errors++; $display("FAIL post_count: got %0d writes required %0d", n, HALF); return; end
        checks++; if (int'(trig_addr) != exp_addr(ti)) begin errors++; $display("FAIL trig_addr: got %0d required %0d", trig_addr, exp_addr(ti)); end
        bad = 0;
        for (int j = 0; j < n; j++) if (wr_addr[ti+j] != exp_addr(ti+j)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL post_addr: %0d wrong addresses, required 0", bad); end
        checks++; if (vr != wr_cyc[ti+n-1] + 1) begin errors++; $display("FAIL valid_latency: rise cycle %0d required %0d", vr, wr_cyc[ti+n-1] + 1); end
        fa = exp_addr(ti + HALF);
        bad = 0;
        repeat (5) begin
            if (mem_en !== 1'b0 || valid !== 1'b1 || triggered !== 1'b1 || int'(mem_addr) != fa) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL done_hold: %0d bad cycles (mem_addr %0d required %0d)", bad, mem_addr, fa); end
    endtask

    task automatic test_capture(input int div);
        int k, trg;
        sample_divider = DEL_W'(div);
        repeat ($urandom_range(0, 30)) tick();
        checks++; if (waiting_for_trigger !== 1'b1) begin errors++; $display("FAIL armed_before_edge: waiting=%b required 1", waiting_for_trigger); end
        k = cyc;
        trigger_req = 1'b1;
        wait_for(1, 20, trg);
        checks++; if (trg != k + 3) begin errors++; $display("FAIL trigger_latency: triggered at %0d required %0d", trg, k + 3); end
        trigger_req = 1'b0;
        test_post_phase(k + 2);
    endtask

    task automatic test_handshake(input int next_mode, output int rise);
        int h, n, i0, bad;
        rise = -1;
        mode = 2'(next_mode);
        bad = 0;
        repeat ($urandom_range(0, 8)) begin
            if (valid !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0 || valid !== 1'b1) begin errors++; $display("FAIL valid_before_ready: valid=%b required 1", valid); end
        h = cyc;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_drop: valid=%b one clock after handshake, required 0", valid); end
        if (next_mode == 2) return;
        wait_for(0, 600, rise);
        checks++;
        if (rise < 0) begin errors++; $display("FAIL resume_timeout: waiting=%b required 1", waiting_for_trigger); return; end
        n = writes_between(h + 1, rise);
        checks++; if (n != HALF) begin errors++; $display("FAIL resume_count: got %0d writes required %0d", n, HALF); end
        i0 = first_write_at(h + 1);
        checks++; if (i0 < 0 || wr_addr[i0] != exp_addr(i0)) begin errors++; $display("FAIL resume_addr: first write addr %0d required %0d", (i0 < 0) ? -1 : wr_addr[i0], exp_addr(i0)); end
    endtask

    task automatic test_div0();
        int bad;
        sample_divider = '0;
        repeat (6) tick();
        bad = 0;
        repeat (8) begin
            if (mem_en !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL div0_every_clock: %0d idle cycles, required 0", bad); end
    endtask

    task automatic test_auto(input int arm_cyc);
        int trg, ia, acc;
        wait_for(1, 400, trg);
        checks++;
        if (trg < 0) begin errors++; $display("FAIL auto_timeout: triggered=%b required 1", triggered); return; end
        ia = first_write_at(arm_cyc);
        checks++;
        if (ia < 0 || ia + FULL > wr_cyc.size()) begin errors++; $display("FAIL auto_early: triggered before %0d armed writes", FULL); return; end
        acc = wr_cyc[ia+FULL-1] + 1;
        checks++; if (trg != acc + 1) begin errors++; $display("FAIL auto_time: triggered at %0d required %0d", trg, acc + 1); end
        test_post_phase(acc);
    endtask

    task automatic test_force(input int arm_cyc);
        checks++; if (waiting_for_trigger !== 1'b1 || triggered !== 1'b0) begin errors++; $display("FAIL force_armed: waiting=%b triggered=%b required 1 0", waiting_for_trigger, triggered); end
        tick();
        checks++; if (waiting_for_trigger !== 1'b0 || triggered !== 1'b1) begin errors++; $display("FAIL force_post: waiting=%b triggered=%b required 0 1", waiting_for_trigger, triggered); end
        test_post_phase(arm_cyc);
    endtask

    task automatic test_stop();
        int r, n0, bad, rel, rise;
        mode = 2'd2;
        test_capture($urandom_range(1, 2));
        test_handshake(2, r);
        n0 = wr_cyc.size();
        bad = 0;
        repeat (40) begin
            if (valid !== 1'b0 || waiting_for_trigger !== 1'b0 || triggered !== 1'b0 || mem_en !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0 || wr_cyc.size() != n0) begin errors++; $display("FAIL hold_idle: %0d active cycles, %0d writes, required 0", bad, wr_cyc.size() - n0); end
        rel = cyc;
        mode = 2'd0;
        wait_for(0, 600, rise);
        checks++;
        if (rise < 0) begin errors++; $display("FAIL hold_release_timeout: waiting=%b required 1", waiting_for_trigger); return; end
        checks++; if (writes_between(rel, rise) != HALF) begin errors++; $display("FAIL hold_release_count: got %0d required %0d", writes_between(rel, rise), HALF); end
    endtask

    task automatic test_wrap();
        int bad, wraps;
        bad = 0; wraps = 0;
        for (int i = addr_base; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != exp_addr(i)) bad++;
            if (i + 1 < wr_addr.size() && wr_addr[i] == FULL - 1 && wr_addr[i+1] == 0) wraps++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL addr_sequence: %0d wrong addresses, required 0", bad); end
        checks++; if (wraps < 1) begin errors++; $display("FAIL addr_wrap: %0d 63->0 wraps seen, required at least 1", wraps); end
    endtask

    task automatic test_reset_mid_post();
        int trg, rise, i0;
        sample_divider = 24'd1;
        trigger_req = 1'b1;
        wait_for(1, 20, trg);
        trigger_req = 1'b0;
        repeat ($urandom_range(2, 20)) tick();
        checks++; if (triggered !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL mid_post_state: triggered=%b valid=%b required 1 0", triggered, valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || mem_addr !== 6'd0 || trig_addr !== 6'd0) begin errors++; $display("FAIL async_reset_bus: mem_en=%b mem_addr=%0d trig_addr=%0d required 0", mem_en, mem_addr, trig_addr); end
        checks++; if (valid !== 1'b0 || waiting_for_trigger !== 1'b0 || triggered !== 1'b0) begin errors++; $display("FAIL async_reset_flags: valid=%b waiting=%b triggered=%b required 0", valid, waiting_for_trigger, triggered); end
        repeat (2) tick();
        addr_base = wr_cyc.size();
        rst_n = 1'b1;
        wait_for(0, 400, rise);
        checks++;
        if (rise < 0) begin errors++; $display("FAIL post_reset_timeout: waiting=%b required 1", waiting_for_trigger); return; end
        i0 = addr_base;
        checks++; if (wr_addr.size() - addr_base != HALF || wr_addr[i0] != 0) begin errors++; $display("FAIL post_reset_fill: %0d writes first addr %0d, required %0d from 0", wr_addr.size() - addr_base, (wr_addr.size() > i0) ? wr_addr[i0] : -1, HALF); end
    endtask

    initial begin
        int r;
        test_reset();
        test_prefill();
        test_capture($urandom_range(1, 3));
        test_handshake(0, r);
        test_div0();
        test_capture(0);
        test_handshake(1, r);
        test_auto(r);
        test_handshake(3, r);
        test_force(r);
        test_handshake(0, r);
        test_stop();
        test_wrap();
        test_reset_mid_post();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
